mi_arbiter: RTL
===============

Name: mi_arbiter

Overview:
- Two-port arbiter sharing the single memory-interface (mi_*) port of the QSPI PSRAM controller.
- Port 0 is the cache refill/writeback path. Port 1 is a secondary bus master, such as a video/DMA streaming engine.
- Sequences one complete burst (command, then all data beats) per grant.
- Routes write/read data strobes only to the granted port, and prevents port-1 starvation with a bounded-priority counter.

Parameters:
- AW, 24, mi address width (words, includes chip-select bits).
- LW, 7, mi_len width (burst = len+1 words).
- DW, 32, data width.
- STARVE_LIM, 4, consecutive port-0 grants allowed while port 1 is pending (range 1..15).

Ports:
- clk_4x_s  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_addr / m1_addr  in  AW  requester burst address.
- m0_len / m1_len  in  LW  requester burst length-1.
- m0_rw / m1_rw  in  1  1 = read, 0 = write.
- m0_valid / m1_valid  in  1  command request.
- m0_ready / m1_ready  out  1  command accepted.
- m0_wdata / m1_wdata  in  DW  write data.
- m0_wack / m1_wack  out  1  write beat consumed.
- m0_wlast / m1_wlast  out  1  last write beat.
- m0_rdata / m1_rdata  out  DW  read data.
- m0_rstb / m1_rstb  out  1  read beat valid.
- m0_rlast / m1_rlast  out  1  last read beat.
- s_addr  out  AW  command address to controller.
- s_len  out  LW  command length to controller.
- s_rw  out  1  command direction to controller.
- s_valid  out  1  command request to controller.
- s_ready  in  1  controller accepted command.
- s_wdata  out  DW  write data to controller.
- s_wack  in  1  controller consumed write beat.
- s_wlast  in  1  controller last write beat.
- s_rdata  in  DW  read data from controller.
- s_rstb  in  1  controller read beat valid.
- s_rlast  in  1  controller last read beat.
- grant  out  1  currently granted port id.
- busy  out  1  arbiter not in IDLE.

Behaviour:
- States and transitions:
  - IDLE: evaluate m0_valid and m1_valid. Any request -> register grant, go to CMD.
  - CMD: drive s_* from the granted port.
  - DATA: route data beats until the last beat, then return to IDLE.
- Grant selection in IDLE:
  - Port 0 wins, unless m1_valid && starve_cnt == STARVE_LIM.
  - Only port 1 valid -> port 1.
  - Neither valid -> stay IDLE.
- Latency: a request sampled in IDLE at edge n gives s_valid=1 from cycle n+1. There is no combinational path from m*_valid to s_valid.
- CMD state:
  - s_addr/s_len/s_rw/s_valid = granted port's inputs.
  - m[grant]_ready = s_ready; the other port's ready = 0.
  - s_valid && s_ready -> latch the rw of the accepted command into dir, go to DATA.
  - Granted valid drops before ready -> back to IDLE with no command issued. starve_cnt is not updated.
- DATA state:
  - s_wdata = granted port's wdata.
  - m[grant]_wack = s_wack and m[grant]_wlast = s_wlast. Ungranted port sees wack/wlast = 0.
  - m*_rdata = s_rdata on both ports, unregistered.
  - rstb/rlast are gated to the granted port only.
  - Exit to IDLE: write (dir=0) on the cycle s_wack && s_wlast; read (dir=1) on the cycle s_rstb && s_rlast.
  - IDLE may grant again on the very next cycle, so bursts run back-to-back with one idle cycle.
- Starvation counter (4-bit):
  - Increments on each port-0 grant made while m1_valid=1.
  - Clears on each port-1 grant.
  - Saturates at STARVE_LIM.
- Outside the granted port: all ready/wack/wlast/rstb/rlast = 0. s_valid = 0 outside CMD.
- s_wdata, when not in DATA: equals port-0 wdata (don't-care for the controller).
- busy = (state != IDLE).
- Reset values:
  - state=IDLE, grant=0, starve_cnt=0, dir=0.
  - All m*_ready/wack/wlast/rstb/rlast = 0; s_valid = 0; busy = 0.
  - s_addr/s_len/s_rw = port-0 inputs (don't-care while s_valid = 0).
- Reset mid-burst: return to IDLE next edge. The controller must be reset by the same rst. Remaining strobes from the controller are ignored.
- Stray s_wack/s_rstb while in IDLE or CMD: not forwarded to either port.

Test Plan:
- Single read: m0 read addr=0x000100, len=7 -> s_valid 1 cycle after m0_valid. After s_ready, 8 m0_rstb pulses, the last with m0_rlast. m1 strobes stay 0. busy drops the cycle after rlast.
- Write routing: m1 write len=3 with wdata 0xA0..0xA3 -> s_wdata follows m1_wdata. 4 m1_wack pulses, m1_wlast on the 4th. m0_wack stays 0.
- Simultaneous requests: m0 and m1 valid at the same cycle -> port 0 granted first (grant=0). Port 1 granted in the IDLE after port 0's last beat.
- Starvation: m0 requests continuously, m1 held valid, STARVE_LIM=4 -> grant sequence 0,0,0,0,1,0...
- Abort and reset: m0_valid drops in CMD before s_ready -> IDLE, no s_valid beyond that cycle. Separately, rst asserted mid-read -> all outputs at reset values next cycle, busy=0.

Source files
------------

// File: rtl/mi_arbiter.sv
// Two-port arbiter in front of the QSPI PSRAM controller's memory interface.
// Port 0 (cache refill/writeback) normally wins; port 1 (streaming master) is
// guaranteed a grant after STARVE_LIM consecutive port-0 grants made while it
// was waiting. Each grant carries one full burst: a command, then every data beat.
module mi_arbiter #(
    parameter int AW         = 24,
    parameter int LW         = 7,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk_4x_s,
    input  logic          rst,
    input  logic [AW-1:0] m0_addr,
    input  logic [LW-1:0] m0_len,
    input  logic          m0_rw,
    input  logic          m0_valid,
    output logic          m0_ready,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_wack,
    output logic          m0_wlast,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rstb,
    output logic          m0_rlast,
    input  logic [AW-1:0] m1_addr,
    input  logic [LW-1:0] m1_len,
    input  logic          m1_rw,
    input  logic          m1_valid,
    output logic          m1_ready,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_wack,
    output logic          m1_wlast,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rstb,
    output logic          m1_rlast,
    output logic [AW-1:0] s_addr,
    output logic [LW-1:0] s_len,
    output logic          s_rw,
    output logic          s_valid,
    input  logic          s_ready,
    output logic [DW-1:0] s_wdata,
    input  logic          s_wack,
    input  logic          s_wlast,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_rstb,
    input  logic          s_rlast,
    output logic          grant,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    state_t     state_reg, state_next;
    logic       grant_reg, grant_next;
    logic [3:0] starve_cnt_reg, starve_cnt_next;
    logic       dir_reg, dir_next;

    // Request fields of whichever port currently holds the grant.
    logic sel_valid;
    logic sel_rw;
    logic pick_m1;
    logic in_cmd;
    logic in_data;

    assign sel_valid = grant_reg ? m1_valid : m0_valid;
    assign sel_rw    = grant_reg ? m1_rw    : m0_rw;
    // Port 1 wins only when it has waited out its quota, or when port 0 is silent.
    assign pick_m1   = m1_valid && ((starve_cnt_reg == LIM) || !m0_valid);
    assign in_cmd    = (state_reg == CMD);
    assign in_data   = (state_reg == DATA);

    // State register: grant, starvation count and burst direction.
    always_ff @(posedge clk_4x_s) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            starve_cnt_reg <= 4'd0;
            dir_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            starve_cnt_reg <= starve_cnt_next;
            dir_reg        <= dir_next;
        end
    end

    // Next-state logic: arbitration in IDLE, handshake in CMD, end-of-burst in DATA.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        starve_cnt_next = starve_cnt_reg;
        dir_next        = dir_reg;
        case (state_reg)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_next = CMD;
                    grant_next = pick_m1;
                    if (pick_m1) begin
                        starve_cnt_next = 4'd0;
                    end else if (m1_valid && (starve_cnt_reg < LIM)) begin
                        starve_cnt_next = starve_cnt_reg + 4'd1;
                    end
                end
            end
            CMD: begin
                if (sel_valid && s_ready) begin
                    state_next = DATA;
                    dir_next   = sel_rw;
                end else if (!sel_valid) begin
                    // Requester withdrew before acceptance: nothing was issued.
                    state_next = IDLE;
                end
            end
            DATA: begin
                if ((!dir_reg && s_wack && s_wlast) || (dir_reg && s_rstb && s_rlast)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: command mux in CMD, strobe routing to the granted port in DATA.
    always_comb begin
        s_addr   = (in_cmd && grant_reg) ? m1_addr : m0_addr;
        s_len    = (in_cmd && grant_reg) ? m1_len  : m0_len;
        s_rw     = (in_cmd && grant_reg) ? m1_rw   : m0_rw;
        s_valid  = in_cmd && sel_valid;
        m0_ready = in_cmd && !grant_reg && s_ready;
        m1_ready = in_cmd &&  grant_reg && s_ready;
        s_wdata  = (in_data && grant_reg) ? m1_wdata : m0_wdata;
        m0_wack  = in_data && !grant_reg && s_wack;
        m0_wlast = in_data && !grant_reg && s_wlast;
        m1_wack  = in_data &&  grant_reg && s_wack;
        m1_wlast = in_data &&  grant_reg && s_wlast;
        m0_rstb  = in_data && !grant_reg && s_rstb;
        m0_rlast = in_data && !grant_reg && s_rlast;
        m1_rstb  = in_data &&  grant_reg && s_rstb;
        m1_rlast = in_data &&  grant_reg && s_rlast;
        // Read data is shared; only the strobes tell a port the beat is its own.
        m0_rdata = s_rdata;
        m1_rdata = s_rdata;
        grant    = grant_reg;
        busy     = (state_reg != IDLE);
    end

endmodule
